// File: rtl/step_clock_gen.sv
// step_clock_gen: single-step / auto-run clock generator for a hand-clocked CPU pipeline.
//
// A bouncing pushbutton is synchronized and debounced. Each accepted press produces one
// cpu_clk pulse of PULSE_HIGH_CYCLES clk cycles. Holding the button does not produce
// more pulses. The button must be released before another pulse can be issued.
//
// Optional feature: define STEP_AUTORUN_EN to compile in auto-run. While the synchronized
// run input is high, a pulse is issued every AUTO_DIV cycles and the button is ignored.
// Without the macro, run is accepted but unused.
//
// Ports:
//   clk          in   board oscillator clock
//   reset        in   asynchronous active-low reset
//   btn          in   raw single-step pushbutton, active-high, asynchronous
//   run          in   auto-run request switch, asynchronous
//   cpu_clk      out  registered step clock
//   cpu_clk_rise out  one-cycle strobe in the first cycle cpu_clk is high
//   step_count   out  pulses issued since reset (wraps)
//   busy         out  FSM not idle
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES   = 100000,
  parameter int unsigned PULSE_HIGH_CYCLES = 4,
  parameter int unsigned AUTO_DIV          = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic        run,
  output logic        cpu_clk,
  output logic        cpu_clk_rise,
  output logic [15:0] step_count,
  output logic        busy
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PhW = $clog2(PULSE_HIGH_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PhW-1:0] PhLast = PhW'(PULSE_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHigh, StWaitRel} state_e;

  logic           btn_meta_q, btn_sync_q;
  logic           btn_stable_q, btn_stable_dly_q, btn_rise_q;
  logic [DbW-1:0] db_cnt_q;
  state_e         state_q, state_d;
  logic [PhW-1:0] high_cnt_q, high_cnt_d;
  logic [15:0]    step_count_q, step_count_d;
  logic           cpu_clk_q, cpu_clk_rise_q, cpu_clk_rise_d;
  logic           btn_press, auto_start, auto_pulse, start;

  // Synchronizer and debouncer. The accepted rise is registered once more so a press
  // reaches the FSM on the cycle after btn_stable rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q       <= 1'b0;
      btn_sync_q       <= 1'b0;
      btn_stable_q     <= 1'b0;
      btn_stable_dly_q <= 1'b0;
      btn_rise_q       <= 1'b0;
      db_cnt_q         <= '0;
    end else begin
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      if (btn_sync_q != btn_stable_q) begin
        if (db_cnt_q == DbLast) begin
          btn_stable_q <= btn_sync_q;
          db_cnt_q     <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
      btn_stable_dly_q <= btn_stable_q;
      btn_rise_q       <= btn_stable_q & ~btn_stable_dly_q;
    end
  end

`ifdef STEP_AUTORUN_EN
  localparam int unsigned AdW = $clog2(AUTO_DIV);
  localparam logic [AdW-1:0] AdLast = AdW'(AUTO_DIV - 1);

  logic           run_meta_q, run_sync_q, auto_pulse_q;
  logic [AdW-1:0] auto_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_meta_q   <= 1'b0;
      run_sync_q   <= 1'b0;
      auto_cnt_q   <= '0;
      auto_pulse_q <= 1'b0;
    end else begin
      run_meta_q <= run;
      run_sync_q <= run_meta_q;
      if (!run_sync_q || (auto_cnt_q == AdLast)) begin
        auto_cnt_q <= '0;
      end else begin
        auto_cnt_q <= auto_cnt_q + AdW'(1);
      end
      // Remember who launched the pulse so an auto pulse can skip the release wait.
      if ((state_q == StIdle) && start) begin
        auto_pulse_q <= auto_start;
      end
    end
  end

  assign auto_start = run_sync_q && (auto_cnt_q == AdLast);
  assign auto_pulse = auto_pulse_q;
  assign btn_press  = btn_rise_q && !run_sync_q;
`else
  logic unused_run;
  assign unused_run = run;
  assign auto_start = 1'b0;
  assign auto_pulse = 1'b0;
  assign btn_press  = btn_rise_q;
`endif

  assign start = btn_press || auto_start;

  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    step_count_d   = step_count_q;
    cpu_clk_rise_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A press seen in any other state is dropped, never queued.
        if (start) begin
          state_d        = StHigh;
          high_cnt_d     = '0;
          step_count_d   = step_count_q + 16'd1;
          cpu_clk_rise_d = 1'b1;
        end
      end
      StHigh: begin
        if (high_cnt_q == PhLast) begin
          state_d = auto_pulse ? StIdle : StWaitRel;
        end else begin
          high_cnt_d = high_cnt_q + PhW'(1);
        end
      end
      StWaitRel: begin
        if (!btn_stable_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      high_cnt_q     <= '0;
      step_count_q   <= '0;
      cpu_clk_q      <= 1'b0;
      cpu_clk_rise_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      step_count_q   <= step_count_d;
      cpu_clk_q      <= (state_d == StHigh);
      cpu_clk_rise_q <= cpu_clk_rise_d;
    end
  end

  assign cpu_clk      = cpu_clk_q;
  assign cpu_clk_rise = cpu_clk_rise_q;
  assign step_count   = step_count_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_step_clock_gen.sv
module tb_step_clock_gen;

  localparam int unsigned D  = 4;
  localparam int unsigned P  = 2;
  localparam int unsigned A  = 8;
  localparam int          HN = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn = 1'b0;
  logic        run = 1'b0;
  logic        cpu_clk, cpu_clk_rise, busy;
  logic [15:0] step_count;

  step_clock_gen #(
    .DEBOUNCE_CYCLES  (D),
    .PULSE_HIGH_CYCLES(P),
    .AUTO_DIV         (A)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .run         (run),
    .cpu_clk     (cpu_clk),
    .cpu_clk_rise(cpu_clk_rise),
    .step_count  (step_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: edge-indexed history of btn, evaluated with window rules.
  bit          bh [HN];
  int          k;
  bit          stable_m;
  int          last_flip, rise_edge, pstart;
  bit          has_pulse, released;
  logic [15:0] cnt_m;

  typedef struct {
    bit          lvl;
    bit          toggle;
    bit          run_req;
    int          hold;
    int          exp_pulses;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit hist(input int i);
    return (i < 0) ? 1'b0 : bh[i % HN];
  endfunction

  task automatic model_reset();
    k         = 0;
    stable_m  = 1'b0;
    last_flip = -1000;
    rise_edge = -1000;
    pstart    = -1000;
    has_pulse = 1'b0;
    released  = 1'b0;
    cnt_m     = 16'h0000;
    for (int i = 0; i < HN; i++) bh[i] = 1'b0;
  endtask

  // Advance the model to edge k, where btn was sampled as b.
  task automatic model_step(input bit b);
    bit busy_prev;
    bit all_diff;
    bh[k % HN] = b;
    busy_prev = has_pulse && !released;
    if (busy_prev && (k >= pstart + int'(P) + 1) && !stable_m) released = 1'b1;
    // Pulse begins two edges after btn_stable rises, if the FSM was idle.
    if ((rise_edge == k - 2) && !busy_prev) begin
      has_pulse = 1'b1;
      released  = 1'b0;
      pstart    = k;
      cnt_m     = cnt_m + 16'd1;
    end
    // Accept a new level once the synchronized value differed for D edges in a row.
    if (k - last_flip >= int'(D)) begin
      all_diff = 1'b1;
      for (int i = k - int'(D) - 1; i <= k - 2; i++) begin
        if (hist(i) == stable_m) all_diff = 1'b0;
      end
      if (all_diff) begin
        stable_m  = !stable_m;
        last_flip = k;
        if (stable_m) rise_edge = k;
      end
    end
  endtask

  task automatic tick(input bit b, input bit r);
    bit exp_cpu, exp_rise, exp_busy;
    @(negedge clk);
    btn = b;
    run = r;
    @(posedge clk);
    model_step(b);
    #1;
    exp_cpu  = has_pulse && (k >= pstart) && (k < pstart + int'(P));
    exp_rise = has_pulse && (k == pstart);
    exp_busy = has_pulse && !released;
    check("cpu_clk", 32'(cpu_clk), 32'(exp_cpu));
    check("cpu_clk_rise", 32'(cpu_clk_rise), 32'(exp_rise));
    check("busy", 32'(busy), 32'(exp_busy));
    check("step_count", 32'(step_count), 32'(cnt_m));
    k++;
  endtask

  task automatic apply_reset(input bit b_hold);
    @(negedge clk);
    reset = 1'b0;
    btn   = b_hold;
    run   = 1'b0;
    #1;
    check("rst_cpu_clk", 32'(cpu_clk), 32'd0);
    check("rst_rise", 32'(cpu_clk_rise), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(step_count), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pulses;
    bit  prev;
    bit  b, r;

    tbl[0] = '{0, 0, 0, 10, 0, 16'd0};
    tbl[1] = '{1, 0, 0, 20, 1, 16'd1};  // clean held press: one pulse
    tbl[2] = '{0, 0, 0, 12, 0, 16'd1};
    tbl[3] = '{0, 1, 0, 30, 0, 16'd1};  // toggling every 2 cycles never debounces
    tbl[4] = '{0, 0, 0, 10, 0, 16'd1};
    tbl[5] = '{1, 0, 0, 3,  0, 16'd1};  // one cycle short of debounce
    tbl[6] = '{0, 0, 0, 10, 0, 16'd1};
    tbl[7] = '{1, 0, 0, 4,  0, 16'd1};  // just long enough; pulse lands in next row
    tbl[8] = '{0, 0, 0, 15, 1, 16'd2};
    tbl[9] = '{0, 0, 1, 20, 0, 16'd2};  // run without a press

    apply_reset(1'b0);

    for (int t = 0; t < 10; t++) begin
      pulses = 0;
      prev   = cpu_clk;
      for (int c = 0; c < tbl[t].hold; c++) begin
        b = tbl[t].toggle ? (((c / 2) % 2) == 0) : tbl[t].lvl;
`ifdef STEP_AUTORUN_EN
        r = 1'b0;
`else
        r = tbl[t].run_req;
`endif
        tick(b, r);
        if (cpu_clk && !prev) pulses++;
        prev = cpu_clk;
      end
      check($sformatf("row%0d_pulses", t), 32'(pulses), 32'(tbl[t].exp_pulses));
      check($sformatf("row%0d_count", t), 32'(step_count), 32'(tbl[t].exp_count));
    end

    // Reset during the second high cycle truncates the pulse immediately.
    apply_reset(1'b0);
    for (int c = 0; c < 9; c++) tick(1'b1, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("midrst_cpu_clk", 32'(cpu_clk), 32'd0);
    check("midrst_count", 32'(step_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    btn = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0);

    // Button already held when reset releases still yields one pulse.
    apply_reset(1'b1);
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
    check("held_release_count", 32'(step_count), 32'd1);
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0);

    // Counter wrap.
    force dut.step_count_q = 16'hFFFF;
    cnt_m = 16'hFFFF;
    tick(1'b0, 1'b0);
    release dut.step_count_q;
    pulses = 0;
    prev   = cpu_clk;
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b0);
      if (cpu_clk && !prev) pulses++;
      prev = cpu_clk;
    end
    check("wrap_count", 32'(step_count), 32'd0);
    check("wrap_pulse", 32'(pulses), 32'd1);
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0);

    // Randomized segments around the debounce threshold.
    for (int s = 0; s < 250; s++) begin
      int len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
`ifdef STEP_AUTORUN_EN
      r = 1'b0;
`else
      r = 1'($urandom_range(0, 1));
`endif
      for (int c = 0; c < len; c++) tick(b, r);
    end

`ifdef STEP_AUTORUN_EN
    // Auto-run: run sampled from edge 0 to 33, btn pressed at 12..21 (must be ignored).
    apply_reset(1'b0);
    for (int e = 0; e < 60; e++) begin
      bit exp_cpu, exp_rise;
      int exp_cnt;
      @(negedge clk);
      btn = (e >= 12) && (e <= 21);
      run = (e <= 33);
      @(posedge clk);
      #1;
      exp_cpu  = (e >= 9) && (e <= 34) && (((e - 9) % 8) < 2);
      exp_rise = (e >= 9) && (e <= 33) && (((e - 9) % 8) == 0);
      exp_cnt  = (e < 9) ? 0 : (((e - 9) / 8 + 1) > 4 ? 4 : ((e - 9) / 8 + 1));
      check("auto_cpu_clk", 32'(cpu_clk), 32'(exp_cpu));
      check("auto_rise", 32'(cpu_clk_rise), 32'(exp_rise));
      check("auto_busy", 32'(busy), 32'(exp_cpu));
      check("auto_count", 32'(step_count), 32'(exp_cnt));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
